// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NUM_REQ byte requesters.
// A granted requester keeps the transmitter until its req_last byte has gone out.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                 clk_50mhz,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 timeout_err,
    output logic                 arb_active
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

    state_t         state, state_next;
    logic [IW-1:0]  ptr, ptr_next;
    logic [IW-1:0]  gidx, gidx_next;
    logic [IW-1:0]  win_idx, cand_idx;
    logic           win_found;
    logic           last_q, last_next;
    logic [CW-1:0]  tmo_cnt, tmo_next;
    int             cand;

    logic [NUM_REQ-1:0] grant_next, req_ready_next;
    logic               tx_start_next, timeout_next;
    logic [7:0]         tx_data_next;

    // Search from the requester just after the last winner, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(ptr) + k) % NUM_REQ;
            cand_idx = IW'(cand);
            if (!win_found && req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= IW'(NUM_REQ - 1);
            gidx        <= '0;
            last_q      <= 1'b0;
            tmo_cnt     <= '0;
            grant       <= '0;
            req_ready   <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            timeout_err <= 1'b0;
            arb_active  <= 1'b0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            gidx        <= gidx_next;
            last_q      <= last_next;
            tmo_cnt     <= tmo_next;
            grant       <= grant_next;
            req_ready   <= req_ready_next;
            tx_start    <= tx_start_next;
            tx_data     <= tx_data_next;
            timeout_err <= timeout_next;
            arb_active  <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        gidx_next  = gidx;
        last_next  = last_q;
        tmo_next   = tmo_cnt;
        case (state)
            IDLE: begin
                if (win_found) begin
                    gidx_next  = win_idx;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (req_valid[gidx] && !tx_busy) begin
                    last_next  = req_last[gidx];
                    tmo_next   = '0;
                    state_next = WAIT_HI;
                end
            end
            WAIT_HI: begin
                // Reaching BUSY_TIMEOUT abandons the message and rotates priority.
                if (tx_busy) begin
                    state_next = WAIT_LO;
                end else if (tmo_cnt == CW'(BUSY_TIMEOUT - 1)) begin
                    state_next = IDLE;
                    ptr_next   = gidx;
                end else begin
                    tmo_next = tmo_cnt + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        state_next = IDLE;
                        ptr_next   = gidx;
                    end else begin
                        state_next = SEND;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Next values for the registered outputs, derived from the transition taken.
    always_comb begin
        grant_next     = '0;
        req_ready_next = '0;
        tx_start_next  = 1'b0;
        tx_data_next   = tx_data;
        timeout_next   = 1'b0;
        if (state_next != IDLE) begin
            grant_next[gidx_next] = 1'b1;
        end
        if (state == SEND && state_next == WAIT_HI) begin
            req_ready_next[gidx] = 1'b1;
            tx_start_next        = 1'b1;
            tx_data_next         = req_data[{gidx, 3'b000} +: 8];
        end
        if (state == WAIT_HI && state_next == IDLE) begin
            timeout_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple behavioural tx_busy responder.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int BUSY_TIMEOUT = 16;

    logic        clk_50mhz = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic        timeout_err;
    logic        arb_active;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int tmo_seen = 0;
    int proto_err = 0;
    int ready_cnt [4] = '{0, 0, 0, 0};
    int bcnt = 0;
    logic busy_stub = 1'b0;

    logic [7:0] t2_bytes [3] = '{8'h00, 8'hFF, 8'hA5};
    logic [3:0] rr_exp [5]   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] rr_data [5]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    int s0, r0;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk_50mhz  (clk_50mhz),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .grant      (grant),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .timeout_err(timeout_err),
        .arb_active (arb_active)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    // uart_tx stand-in: busy rises right after a start and stays up for 6 cycles.
    always @(posedge clk_50mhz) begin
        #2;
        if (tx_start && !busy_stub) bcnt = 6;
        if (bcnt > 0) begin
            tx_busy = 1'b1;
            bcnt--;
        end else begin
            tx_busy = 1'b0;
        end
    end

    always @(posedge clk_50mhz) begin
        #1;
        if (tx_start) start_cnt++;
        if (timeout_err) tmo_seen++;
        for (int i = 0; i < 4; i++) if (req_ready[i]) ready_cnt[i]++;
        if (((req_ready & (req_ready - 4'd1)) != 4'd0) || ((req_ready & ~grant) != 4'd0)) proto_err++;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l);
        req_valid = v;
        req_data  = d;
        req_last  = l;
    endtask

    task automatic waitStart(input string tag);
        int n = 0;
        do begin
            @(negedge clk_50mhz);
            n++;
        end while (!tx_start && n < 200);
        checkOutput(tag, 32'(tx_start), 32'd1);
    endtask

    task automatic waitBusy(input logic lvl, input string tag);
        int n = 0;
        while (tx_busy !== lvl && n < 100) begin
            @(negedge clk_50mhz);
            n++;
        end
        checkOutput(tag, 32'(tx_busy), 32'(lvl));
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        do begin
            @(negedge clk_50mhz);
            n++;
        end while (grant != 4'd0 && n < 200);
        checkOutput(tag, 32'(grant), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(4'd0, 32'd0, 4'd0);
        repeat (3) @(negedge clk_50mhz);
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_start", 32'(tx_start), 32'd0);
        checkOutput("rst_data", 32'(tx_data), 32'd0);
        checkOutput("rst_tmo", 32'(timeout_err), 32'd0);
        checkOutput("rst_active", 32'(arb_active), 32'd0);
        rst = 1'b0;
        @(negedge clk_50mhz);

        // Single byte from req0, exact cycle timing.
        applyStimulus(4'b0001, 32'h0000_0055, 4'b0001);
        @(negedge clk_50mhz);
        checkOutput("t1_grant", 32'(grant), 32'h1);
        checkOutput("t1_nostart", 32'(tx_start), 32'd0);
        checkOutput("t1_active", 32'(arb_active), 32'd1);
        @(negedge clk_50mhz);
        checkOutput("t1_start", 32'(tx_start), 32'd1);
        checkOutput("t1_data", 32'(tx_data), 32'h55);
        checkOutput("t1_ready", 32'(req_ready), 32'h1);
        applyStimulus(4'd0, 32'd0, 4'd0);
        waitBusy(1'b1, "t1_busy_hi");
        waitBusy(1'b0, "t1_busy_lo");
        checkOutput("t1_grant_hold", 32'(grant), 32'h1);
        @(negedge clk_50mhz);
        checkOutput("t1_grant_drop", 32'(grant), 32'd0);
        checkOutput("t1_inactive", 32'(arb_active), 32'd0);

        // Message lock: req1 sends three bytes while req2 waits.
        r0 = ready_cnt[1];
        s0 = start_cnt;
        for (int b = 0; b < 3; b++) begin
            applyStimulus(4'b0110, {8'h00, 8'h22, t2_bytes[b], 8'h00}, {1'b0, 1'b1, (b == 2), 1'b0});
            waitStart($sformatf("t2_start%0d", b));
            checkOutput($sformatf("t2_data%0d", b), 32'(tx_data), 32'(t2_bytes[b]));
            checkOutput($sformatf("t2_grant%0d", b), 32'(grant), 32'h2);
        end
        checkOutput("t2_ready1_cnt", 32'(ready_cnt[1] - r0), 32'd3);
        checkOutput("t2_start_cnt", 32'(start_cnt - s0), 32'd3);
        for (int n = 0; n < 100 && grant == 4'b0010; n++) @(negedge clk_50mhz);
        checkOutput("t2_gap", 32'(grant), 32'd0);
        @(negedge clk_50mhz);
        checkOutput("t2_grant2", 32'(grant), 32'h4);
        waitStart("t2_req2_start");
        checkOutput("t2_req2_data", 32'(tx_data), 32'h22);
        applyStimulus(4'd0, 32'd0, 4'd0);
        waitIdle("t2_idle");

        // Stall inside a message from req3.
        applyStimulus(4'b1000, 32'h3100_0000, 4'b0000);
        waitStart("t3_start1");
        checkOutput("t3_data1", 32'(tx_data), 32'h31);
        applyStimulus(4'd0, 32'd0, 4'd0);
        s0 = start_cnt;
        repeat (100) @(negedge clk_50mhz);
        checkOutput("t3_no_start", 32'(start_cnt - s0), 32'd0);
        checkOutput("t3_grant_held", 32'(grant), 32'h8);
        applyStimulus(4'b1000, 32'h3200_0000, 4'b1000);
        @(negedge clk_50mhz);
        checkOutput("t3_resume", 32'(tx_start), 32'd1);
        checkOutput("t3_data2", 32'(tx_data), 32'h32);
        applyStimulus(4'd0, 32'd0, 4'd0);
        waitIdle("t3_idle");

        // Round-robin with every requester always valid.
        applyStimulus(4'b1111, 32'h4433_2211, 4'b1111);
        for (int m = 0; m < 5; m++) begin
            waitStart($sformatf("t4_start%0d", m));
            checkOutput($sformatf("t4_ready%0d", m), 32'(req_ready), 32'(rr_exp[m]));
            checkOutput($sformatf("t4_grant%0d", m), 32'(grant), 32'(rr_exp[m]));
            checkOutput($sformatf("t4_data%0d", m), 32'(tx_data), 32'(rr_data[m]));
        end
        applyStimulus(4'd0, 32'd0, 4'd0);
        waitIdle("t4_idle");

        // Busy handshake timeout.
        busy_stub = 1'b1;
        s0 = tmo_seen;
        applyStimulus(4'b0001, 32'h0000_0077, 4'b0001);
        waitStart("t5_start");
        repeat (BUSY_TIMEOUT - 1) @(negedge clk_50mhz);
        checkOutput("t5_early", 32'(timeout_err), 32'd0);
        @(negedge clk_50mhz);
        checkOutput("t5_tmo", 32'(timeout_err), 32'd1);
        checkOutput("t5_grant0", 32'(grant), 32'd0);
        checkOutput("t5_inactive", 32'(arb_active), 32'd0);
        busy_stub = 1'b0;
        applyStimulus(4'b0011, 32'h0000_8877, 4'b0011);
        @(negedge clk_50mhz);
        checkOutput("t5_next_rr", 32'(grant), 32'h2);
        waitStart("t5_req1_start");
        checkOutput("t5_req1_data", 32'(tx_data), 32'h88);
        applyStimulus(4'd0, 32'd0, 4'd0);
        waitIdle("t5_idle");
        checkOutput("t5_tmo_cnt", 32'(tmo_seen - s0), 32'd1);

        // Reset during WAIT_LO of byte 2 of a 4-byte message.
        applyStimulus(4'b0001, 32'h0000_0001, 4'b0000);
        waitStart("t6_b1");
        applyStimulus(4'b0001, 32'h0000_0002, 4'b0000);
        waitStart("t6_b2");
        checkOutput("t6_data2", 32'(tx_data), 32'h02);
        waitBusy(1'b1, "t6_busy_hi");
        @(negedge clk_50mhz);
        checkOutput("t6_waitlo", 32'(arb_active), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t6_grant", 32'(grant), 32'd0);
        checkOutput("t6_ready", 32'(req_ready), 32'd0);
        checkOutput("t6_start", 32'(tx_start), 32'd0);
        checkOutput("t6_txdata", 32'(tx_data), 32'd0);
        checkOutput("t6_tmo", 32'(timeout_err), 32'd0);
        checkOutput("t6_active", 32'(arb_active), 32'd0);
        applyStimulus(4'b0011, 32'h0000_BBAA, 4'b0011);
        @(negedge clk_50mhz);
        rst = 1'b0;
        @(negedge clk_50mhz);
        checkOutput("t6_first_grant", 32'(grant), 32'h1);

        checkOutput("proto_ready", 32'(proto_err), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
